// File: rtl/pwm_capture_if.sv
// Servo-PWM receiver bundle: raw PWM input plus the measured-pulse result set.
// The capture block owns the master side; the consumer (or bench) the slave side.
interface pwm_capture_if;
  logic        pwm_in;
  logic [10:0] pos_val;
  logic [14:0] width_us;
  logic        valid;
  logic        clamped;
  logic        rej_err;
  logic        lost;

  modport master (
    input  pwm_in,
    output pos_val,
    output width_us,
    output valid,
    output clamped,
    output rej_err,
    output lost
  );

  modport slave (
    output pwm_in,
    input  pos_val,
    input  width_us,
    input  valid,
    input  clamped,
    input  rej_err,
    input  lost
  );
endinterface

// File: rtl/pwm_capture.sv
// Servo-PWM receiver: measures the high time of a servo pulse in 1 us steps,
// reports raw and clamped widths, discards glitches/over-long pulses and flags
// loss of signal when no rising edge arrives for TIMEOUT_US.
module pwm_capture #(
  parameter int CLK_DIV    = 32'd100,
  parameter int MIN_US     = 32'd1000,
  parameter int MAX_US     = 32'd2000,
  parameter int REJ_LO_US  = 32'd500,
  parameter int REJ_HI_US  = 32'd2500,
  parameter int TIMEOUT_US = 32'd25000
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.master bus
);

  localparam int              PRE_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [14:0]     MIN_W     = 15'(MIN_US);
  localparam logic [14:0]     MAX_W     = 15'(MAX_US);
  localparam logic [14:0]     REJ_LO_W  = 15'(REJ_LO_US);
  localparam logic [14:0]     REJ_HI_W  = 15'(REJ_HI_US);
  localparam logic [14:0]     TIMEOUT_W = 15'(TIMEOUT_US);
  localparam logic [14:0]     US_SAT    = 15'h7FFF;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // Clamp a raw width onto the position scale used by the PWM generator.
  function automatic logic [10:0] clamp_pos(input logic [14:0] w);
    logic [14:0] c;
    if (w < MIN_W) begin
      c = MIN_W;
    end else if (w > MAX_W) begin
      c = MAX_W;
    end else begin
      c = w;
    end
    return 11'(c);
  endfunction

  logic             sync1_r, sync2_r, dly_r;
  logic             rise_r, fall_r;
  logic [PRE_W-1:0] pre_r;
  logic [14:0]      us_r;
  logic [14:0]      us_inc_s;
  logic             tick_s;
  state_t           state_r, state_nxt_s;
  logic             cnt_clr_s, accept_s, reject_s, lost_set_s, lost_clr_s;
  logic [10:0]      pos_r;
  logic [14:0]      width_r;
  logic             valid_r, clamped_r, rej_r, lost_r;

  // Synchronizer, delayed copy and registered edge strobes; the chain resets
  // to "high" so a pulse already in progress at reset release is never seen
  // as a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      dly_r   <= 1'b1;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= bus.pwm_in;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
      rise_r  <= sync2_r & ~dly_r;
      fall_r  <= ~sync2_r & dly_r;
    end
  end

  // Tick decode and saturating next value of the microsecond counter; the
  // fall evaluation uses the next value so width = floor(cycles / CLK_DIV).
  always_comb begin
    tick_s   = (pre_r == PRE_TC);
    us_inc_s = us_r;
    if (tick_s && (us_r != US_SAT)) begin
      us_inc_s = us_r + 15'd1;
    end else begin
      us_inc_s = us_r;
    end
  end

  // Prescaler and microsecond counter, restarted on rise and state changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_r <= '0;
      us_r  <= 15'd0;
    end else if (cnt_clr_s) begin
      pre_r <= '0;
      us_r  <= 15'd0;
    end else begin
      if (tick_s) begin
        pre_r <= '0;
      end else begin
        pre_r <= pre_r + PRE_ONE;
      end
      us_r <= us_inc_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_ARM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and control decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    lost_set_s  = 1'b0;
    lost_clr_s  = 1'b0;
    case (state_r)
      ST_ARM: begin
        cnt_clr_s = 1'b1;
        if (!sync2_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (rise_r) begin
          state_nxt_s = ST_HIGH;
          cnt_clr_s   = 1'b1;
          lost_clr_s  = 1'b1;
        end else if (us_r >= TIMEOUT_W) begin
          lost_set_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (fall_r) begin
          state_nxt_s = ST_IDLE;
          cnt_clr_s   = 1'b1;
          if ((us_inc_s >= REJ_LO_W) && (us_inc_s <= REJ_HI_W)) begin
            accept_s = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end else if (us_r > REJ_HI_W) begin
          state_nxt_s = ST_ARM;
          cnt_clr_s   = 1'b1;
          reject_s    = 1'b1;
        end else begin
          state_nxt_s = ST_HIGH;
        end
      end
      default: begin
        state_nxt_s = ST_ARM;
        cnt_clr_s   = 1'b1;
      end
    endcase
  end

  // Result registers and status strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_r     <= 11'(MIN_US);
      width_r   <= 15'd0;
      valid_r   <= 1'b0;
      clamped_r <= 1'b0;
      rej_r     <= 1'b0;
      lost_r    <= 1'b1;
    end else begin
      valid_r <= accept_s;
      rej_r   <= reject_s;
      if (accept_s) begin
        width_r   <= us_inc_s;
        pos_r     <= clamp_pos(us_inc_s);
        clamped_r <= (us_inc_s < MIN_W) | (us_inc_s > MAX_W);
      end
      if (lost_clr_s) begin
        lost_r <= 1'b0;
      end else if (lost_set_s) begin
        lost_r <= 1'b1;
      end
    end
  end

  assign bus.pos_val  = pos_r;
  assign bus.width_us = width_r;
  assign bus.valid    = valid_r;
  assign bus.clamped  = clamped_r;
  assign bus.rej_err  = rej_r;
  assign bus.lost     = lost_r;

endmodule
